uart_rx: RTL

- Serial receiver for the team's UART link. It deserialises frames on rx_line: start bit (0), 8 data bits LSB first, one even-parity bit (parity = XOR of the data byte), stop bit (1).
- It is the receive half of the full-duplex UART and pairs with the existing transmitter at the same bit time.
- Received bytes and error flags go to the board logic (LEDs / register file) with a one-cycle valid strobe.

---
 rtl/uart_rx.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx: UART receive half.
//
// Frame format on rx_line: start bit (0), 8 data bits LSB first, one even
// parity bit (XOR of the data byte), one stop bit (1). Every bit is
// BIT_COUNTS clock cycles long.
//
// Ports
//   clk        in   system clock
//   n_rst      in   asynchronous reset, active low
//   rx_line    in   serial input, asynchronous to clk, idles high
//   data       out  last received byte
//   rx_valid   out  one-cycle strobe: a frame completed
//   parity_err out  last frame's parity bit did not match XOR(data)
//   frame_err  out  last frame's stop bit was sampled low
//   busy       out  receiver FSM is not idle (also serves as state visibility)
//
// Output semantics: rx_valid is a plain strobe with no ready/backpressure.
// data, parity_err and frame_err change only in the cycle rx_valid is high
// and hold until the next strobe; the consumer must capture them on that
// cycle. Frames with errors still strobe rx_valid. Overrun is not detected.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int BIT_COUNTS  = 20,
    parameter int HALF_COUNTS = BIT_COUNTS / 2,
    parameter int CNT_W       = 13
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rx_line,
    output logic [7:0] data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_COUNTS - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_COUNTS - 1);

    state_t           state;
    state_t           state_next;
    logic             sync_1;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       shreg;
    logic             p_bit;
    logic             tick;
    logic             frame_done;

    // Two-flop synchroniser; both flops reset to the idle line level so
    // reset release never looks like a start bit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= rx_line;
            rx_s   <= sync_1;
        end
    end

    // START ticks after half a bit so all later samples land mid-bit.
    always_comb begin
        tick = 1'b0;
        case (state)
            S_START:                  tick = (cnt == HALF_LAST);
            S_DATA, S_PARITY, S_STOP: tick = (cnt == BIT_LAST);
            default:                  tick = 1'b0;
        endcase
    end

    assign frame_done = (state == S_STOP) && tick;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!rx_s) state_next = S_START;
            end
            S_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (tick) state_next = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (tick && (bit_idx == 4'd7)) state_next = S_PARITY;
            end
            S_PARITY: begin
                if (tick) state_next = S_STOP;
            end
            S_STOP: begin
                // A low stop bit means the line may be held in break; wait
                // for it to recover rather than retriggering on it.
                if (tick) state_next = rx_s ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (rx_s) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Bit-time counter: restarts on every state entry and on every tick so
    // consecutive data bits are each timed from the previous sample point.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if ((state_next != state) || tick) begin
            cnt <= '0;
        end else if ((state == S_IDLE) || (state == S_BREAK)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Receive datapath: right-shift so the first bit ends up in bit 0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_idx <= 4'd0;
            shreg   <= 8'h00;
            p_bit   <= 1'b0;
        end else begin
            if ((state == S_START) && tick) begin
                bit_idx <= 4'd0;
            end else if ((state == S_DATA) && tick) begin
                bit_idx <= bit_idx + 4'd1;
                shreg   <= {rx_s, shreg[7:1]};
            end
            if ((state == S_PARITY) && tick) begin
                p_bit <= rx_s;
            end
        end
    end

    // Result registers, updated together with the strobe.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data       <= 8'h00;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= frame_done;
            if (frame_done) begin
                data       <= shreg;
                parity_err <= p_bit ^ (^shreg);
                frame_err  <= ~rx_s;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule
